// File: rtl/music_score_if.sv
// music_score_if: control, score-ROM and tone-generator signals of music_score_player.
// tempo_sel exists only when MUSIC_TEMPO_SEL_EN is defined.
interface music_score_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int ROM_WIDTH  = 12
);
   logic                  play, pause, stop, loop_en;
`ifdef MUSIC_TEMPO_SEL_EN
   logic [1:0]            tempo_sel;
`endif
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [ROM_WIDTH-1:0]  rom_data, note_code;
   logic                  note_on, beat_tick, busy, done;
`ifdef MUSIC_TEMPO_SEL_EN
   modport master (output play, pause, stop, loop_en, tempo_sel, rom_data,
                   input rom_addr, note_code, note_on, beat_tick, busy, done);
   modport slave  (input play, pause, stop, loop_en, tempo_sel, rom_data,
                   output rom_addr, note_code, note_on, beat_tick, busy, done);
`else
   modport master (output play, pause, stop, loop_en, rom_data,
                   input rom_addr, note_code, note_on, beat_tick, busy, done);
   modport slave  (input play, pause, stop, loop_en, rom_data,
                   output rom_addr, note_code, note_on, beat_tick, busy, done);
`endif
endinterface

// File: rtl/music_score_player.sv
// music_score_player: steps the score ROM once per beat and registers the note word.
// Define MUSIC_TEMPO_SEL_EN to add per-beat tempo selection (tempo_sel).
module music_score_player #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int ROM_DEPTH   = 135,
   parameter int ADDR_WIDTH  = 8,
   parameter int ROM_WIDTH   = 12
) (
   input logic          clk,
   input logic          rst,
   music_score_if.slave bus
);
`ifdef MUSIC_TEMPO_SEL_EN
   localparam int CW = $clog2(2 * BEAT_CYCLES);
`else
   localparam int CW = $clog2(BEAT_CYCLES);
`endif
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);
   localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);

   if (BEAT_CYCLES < 4 || ROM_DEPTH > (1 << ADDR_WIDTH) || CLK_FREQ <= 0) begin : g_bad_params
      $error("music_score_player: invalid parameters");
   end

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         cnt_q, cnt_d, last;
   logic [ROM_WIDTH-1:0]  note_q, note_d;
   logic                  run, go, tick, wrap;
`ifdef MUSIC_TEMPO_SEL_EN
   logic [CW-1:0]         last_q, last_d, sel_last;
`endif

   always_comb begin
      run     = state_q == S_PLAY;
      go      = bus.play && !bus.pause && !bus.stop;
`ifdef MUSIC_TEMPO_SEL_EN
      last     = last_q;
      sel_last = bus.tempo_sel == 2'b01 ? CW'(2 * BEAT_CYCLES - 1) :
                 bus.tempo_sel == 2'b10 ? CW'(BEAT_CYCLES / 2 - 1) : CW'(BEAT_CYCLES - 1);
`else
      last    = BEAT_LAST;
`endif
      tick    = run && cnt_q == last && !bus.stop;
      wrap    = tick && addr_q == LAST_ADDR;
      // a song that ends without loop_en returns to IDLE even if pause is also held
      state_d = bus.stop ? S_IDLE :
                run ? (wrap && !bus.loop_en ? S_IDLE : bus.pause ? S_PAUSE : S_PLAY) :
                go ? S_PLAY : state_q;
      cnt_d   = bus.stop || state_q == S_IDLE ? '0 :
                !run || (bus.pause && !tick) ? cnt_q :
                tick ? '0 : cnt_q + 1'b1;
      addr_d  = bus.stop || state_q == S_IDLE || wrap ? '0 : tick ? addr_q + 1'b1 : addr_q;
      note_d  = run && state_d == S_PLAY ? bus.rom_data : '0;
`ifdef MUSIC_TEMPO_SEL_EN
      last_d  = tick || (state_q == S_IDLE && go) ? sel_last : last_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         note_q  <= '0;
`ifdef MUSIC_TEMPO_SEL_EN
         last_q  <= BEAT_LAST;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
`ifdef MUSIC_TEMPO_SEL_EN
         last_q  <= last_d;
`endif
      end
   end

   assign bus.rom_addr  = addr_q;
   assign bus.note_code = note_q;
   assign bus.note_on   = run && note_q != '0;
   assign bus.beat_tick = tick;
   assign bus.busy      = state_q != S_IDLE;
   assign bus.done      = wrap;
endmodule

// File: doc/music_score_player.md
Name: music_score_player

Overview:
- Sequencer for the buzzer music score ROM. It steps the ROM address once per beat and registers the 12-bit note word {high[3:0], med[3:0], low[3:0]} for the tone generator.
- Handles play/pause/stop, end-of-song and looping.
- Sits between the top-level control logic and the score ROM / buzzer tone generator.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz; documentation only, not used in logic.
- BEAT_CYCLES, 25_000_000: clock cycles per beat (250 ms at 100 MHz). Must be ≥ 4.
- ROM_DEPTH, 135: number of beats in the score. Last address is ROM_DEPTH-1.
- ADDR_WIDTH, 8: ROM address width. Must satisfy 2^ADDR_WIDTH ≥ ROM_DEPTH.
- ROM_WIDTH, 12: ROM word width.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- play, input, 1: level. Start from IDLE, or resume from PAUSED.
- pause, input, 1: level. Freeze playback.
- stop, input, 1: level. Abort to IDLE.
- loop_en, input, 1: restart at address 0 after the last beat.
- rom_addr, output, ADDR_WIDTH: address to the score ROM. Registered.
- rom_data, input, ROM_WIDTH: combinational ROM read data.
- note_code, output, ROM_WIDTH: registered note word to the tone generator. Zero means silence.
- note_on, output, 1: note_code is non-zero and the block is in PLAY.
- beat_tick, output, 1: one-cycle pulse on the last cycle of each beat.
- busy, output, 1: state is PLAY or PAUSED.
- done, output, 1: one-cycle pulse when the last beat completes.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, rst.
- Reset: state IDLE; rom_addr=0, beat_cnt=0; note_code=0; note_on, beat_tick, busy, done = 0.
- Command priority, evaluated every cycle: stop > pause > play.
- IDLE:
  - play → PLAY; rom_addr=0, beat_cnt=0.
  - Otherwise hold all outputs at reset values.
- PLAY:
  - beat_cnt increments each cycle.
  - When beat_cnt==BEAT_CYCLES-1: beat_tick=1, beat_cnt←0, and rom_addr advances.
  - When rom_addr==ROM_DEPTH-1 at that tick (wrap):
    - done=1 and rom_addr←0.
    - If loop_en is sampled 1 on the same cycle, stay in PLAY.
    - Otherwise go to IDLE with note_code←0.
  - pause → PAUSED. beat_cnt and rom_addr are frozen.
  - stop → IDLE. rom_addr←0, beat_cnt←0, note_code←0.
- PAUSED:
  - note_code←0 and note_on=0; counters are held.
  - play with pause=0 → PLAY. The beat resumes at the frozen beat_cnt.
  - stop → IDLE.
- note_code latency:
  - In PLAY, note_code←rom_data every cycle, so it reflects rom_addr with one cycle of latency.
  - The first note appears 2 cycles after play is sampled in IDLE.
- note_on:
  - note_on=(note_code!=0) while in PLAY.
  - An all-zero ROM word is a rest: note_on=0 for that beat.
- Repeated identical words on consecutive beats form one sustained note. No re-articulation gap.
- busy is combinational from the state.
- Simultaneous events:
  - stop on the final tick: stop wins and done is not asserted.
  - pause on a tick cycle: the tick completes first, then the block enters PAUSED with beat_cnt=0 and rom_addr already advanced.
  - play and pause both asserted in IDLE: stay in IDLE.
- rst mid-song: returns to the reset state on the next edge, regardless of state.
- rom_addr never exceeds ROM_DEPTH-1.
- beat_cnt width is $clog2(BEAT_CYCLES). Counter arithmetic is unsigned, with explicit compare-and-clear, no natural overflow.

Optional Feature:
- Macro: MUSIC_TEMPO_SEL_EN.
- When defined:
  - Adds input tempo_sel[1:0]. Beat length: 00 = BEAT_CYCLES; 01 = 2×BEAT_CYCLES (half speed); 10 = BEAT_CYCLES/2 (double speed); 11 = BEAT_CYCLES.
  - tempo_sel is sampled only at beat start (IDLE→PLAY or beat_cnt←0). A mid-beat change takes effect at the next beat.
  - beat_cnt widens to cover 2×BEAT_CYCLES.
- When undefined: no tempo_sel port, fixed BEAT_CYCLES, and behaviour identical to the above with tempo_sel=00.

Test Plan:
- Bench settings: BEAT_CYCLES=4, ROM_DEPTH=135, driven by a ROM model with the real score.
- Test 1, normal play: reset, then play=1 for 1 cycle.
  - Expect rom_addr=0, then 1 after 4 cycles.
  - Expect note_code=0x003 from cycle 2; beat_tick every 4 cycles.
  - Beat 8 gives note_code=0x010; beat 19 gives note_code=0x100.
- Test 2, rest beat: at addr 30/31 (word 0x000), expect note_on=0 and busy=1. At addr 32, note_code=0x020 and note_on=1.
- Test 3, end of song with loop_en=0: after 135×4 cycles, done pulses exactly once. Then state IDLE, rom_addr=0, note_code=0, busy=0.
- Test 4, end of song with loop_en=1: done pulses and rom_addr wraps 134→0. note_code returns to 0x003 and busy stays 1.
- Test 5, pause and resume: pause at addr 10 with beat_cnt=2.
  - Hold pause for 20 cycles: note_code=0, rom_addr=10.
  - Then play: the remaining beat lasts 2 cycles before the tick to addr 11.
- Test 6, stop precedence: assert stop and pause together at the final tick. Expect done=0, IDLE, rom_addr=0.
  - With MUSIC_TEMPO_SEL_EN and tempo_sel=01, beat_tick spacing is 8 cycles.
